// File: rtl/ama_riscv_mmio_pkg.sv
// Shared widths and types for the MMIO stage and the blocks around it.
package ama_riscv_mmio_pkg;
  localparam int MMIO_CNT_W = 32;
  localparam int UART_DW    = 8;

  typedef logic [UART_DW-1:0] uart_byte_t;
endpackage

// File: rtl/ama_riscv_fifo.sv
// Small synchronous FIFO with wrap-bit pointers and asynchronous reset.
module ama_riscv_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head reads 0 while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/ama_riscv_mmio.sv
// MMIO stage: cycle/instr counters, core-to-UART TX FIFO, UART-to-core RX holding register.
module ama_riscv_mmio
  import ama_riscv_mmio_pkg::*;
#(
  parameter int TX_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_wb_nop_or_clear,
  input  logic                  mmio_reset_cnt,
  input  logic                  store_to_uart,
  input  logic [UART_DW-1:0]    mmio_uart_data_in,
  input  logic                  load_from_uart,
  output logic [MMIO_CNT_W-1:0] mmio_cycle_cnt,
  output logic [MMIO_CNT_W-1:0] mmio_instr_cnt,
  output logic [UART_DW-1:0]    mmio_uart_data_out,
  output logic                  mmio_data_out_valid,
  output logic                  mmio_data_in_ready,
  output logic [UART_DW-1:0]    tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [UART_DW-1:0]    rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  tx_overflow
);
  logic [MMIO_CNT_W-1:0] cycle_q, instr_q;
  uart_byte_t            rx_byte_q;
  logic                  rx_full_q;
  logic                  ovf_q;
  logic                  tx_full, tx_empty;

  assign mmio_cycle_cnt = cycle_q;
  assign mmio_instr_cnt = instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else if (mmio_reset_cnt) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (!inst_wb_nop_or_clear) instr_q <= instr_q + 1'b1;
    end
  end

  ama_riscv_fifo #(.DW(UART_DW), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (store_to_uart),
    .push_data (mmio_uart_data_in),
    .pop       (tx_ready),
    .pop_data  (tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign tx_valid           = !tx_empty;
  assign mmio_data_in_ready = !tx_full;
  assign tx_overflow        = ovf_q;

  // A dropped store outranks a counter clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ovf_q <= 1'b0;
    else if (store_to_uart && tx_full) ovf_q <= 1'b1;
    else if (mmio_reset_cnt)          ovf_q <= 1'b0;
  end

  assign rx_ready            = !rx_full_q;
  assign mmio_data_out_valid = rx_full_q;
  assign mmio_uart_data_out  = rx_byte_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_full_q <= 1'b0;
      rx_byte_q <= '0;
    end else if (rx_valid && !rx_full_q) begin
      rx_full_q <= 1'b1;
      rx_byte_q <= rx_data;
    end else if (load_from_uart) begin
      rx_full_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ama_riscv_mmio.sv
// Directed bench for ama_riscv_mmio: counters, TX FIFO, RX register, async reset.
module tb_ama_riscv_mmio;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_wb_nop_or_clear, mmio_reset_cnt, store_to_uart, load_from_uart;
  logic [7:0]  mmio_uart_data_in, mmio_uart_data_out, tx_data, rx_data;
  logic [31:0] mmio_cycle_cnt, mmio_instr_cnt;
  logic        mmio_data_out_valid, mmio_data_in_ready, tx_valid, tx_ready;
  logic        rx_valid, rx_ready, tx_overflow;

  int checks = 0;
  int errors = 0;

  ama_riscv_mmio #(.TX_DEPTH(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .inst_wb_nop_or_clear (inst_wb_nop_or_clear),
    .mmio_reset_cnt       (mmio_reset_cnt),
    .store_to_uart        (store_to_uart),
    .mmio_uart_data_in    (mmio_uart_data_in),
    .load_from_uart       (load_from_uart),
    .mmio_cycle_cnt       (mmio_cycle_cnt),
    .mmio_instr_cnt       (mmio_instr_cnt),
    .mmio_uart_data_out   (mmio_uart_data_out),
    .mmio_data_out_valid  (mmio_data_out_valid),
    .mmio_data_in_ready   (mmio_data_in_ready),
    .tx_data              (tx_data),
    .tx_valid             (tx_valid),
    .tx_ready             (tx_ready),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .rx_ready             (rx_ready),
    .tx_overflow          (tx_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cyc"},   mmio_cycle_cnt, 32'd0);
    chk({tag, "_ins"},   mmio_instr_cnt, 32'd0);
    chk({tag, "_txv"},   {31'd0, tx_valid}, 32'd0);
    chk({tag, "_txd"},   {24'd0, tx_data}, 32'd0);
    chk({tag, "_inrdy"}, {31'd0, mmio_data_in_ready}, 32'd1);
    chk({tag, "_outv"},  {31'd0, mmio_data_out_valid}, 32'd0);
    chk({tag, "_outd"},  {24'd0, mmio_uart_data_out}, 32'd0);
    chk({tag, "_rxrdy"}, {31'd0, rx_ready}, 32'd1);
    chk({tag, "_ovf"},   {31'd0, tx_overflow}, 32'd0);
  endtask

  task automatic store(input logic [7:0] b);
    store_to_uart = 1'b1;
    mmio_uart_data_in = b;
    @(negedge clk);
    store_to_uart = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_seq [4];
    rst = 1'b1;
    inst_wb_nop_or_clear = 1'b1; mmio_reset_cnt = 1'b0;
    store_to_uart = 1'b0; mmio_uart_data_in = 8'h00; load_from_uart = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    chk("cyc_first", mmio_cycle_cnt, 32'd0);

    // 10 cycles, retire on every other one
    for (int i = 0; i < 10; i++) begin
      inst_wb_nop_or_clear = (i % 2 == 0);
      @(negedge clk);
    end
    chk("cyc_10", mmio_cycle_cnt, 32'd10);
    chk("ins_5",  mmio_instr_cnt, 32'd5);

    // wrap via backdoor
    inst_wb_nop_or_clear = 1'b0;
    dut.cycle_q = 32'hFFFF_FFFF;
    dut.instr_q = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("cyc_wrap", mmio_cycle_cnt, 32'd0);
    chk("ins_wrap", mmio_instr_cnt, 32'd0);
    repeat (3) @(negedge clk);
    mmio_reset_cnt = 1'b1;
    @(negedge clk);
    mmio_reset_cnt = 1'b0;
    chk("cyc_clr", mmio_cycle_cnt, 32'd0);
    chk("ins_clr", mmio_instr_cnt, 32'd0);
    @(negedge clk);
    chk("cyc_clr1", mmio_cycle_cnt, 32'd1);
    chk("ins_clr1", mmio_instr_cnt, 32'd1);

    // fill TX FIFO with tx_ready low
    store(8'h41);
    chk("tx_lat_v", {31'd0, tx_valid}, 32'd1);
    chk("tx_lat_d", {24'd0, tx_data}, 32'h41);
    store(8'h42);
    store(8'h43);
    chk("inrdy_3", {31'd0, mmio_data_in_ready}, 32'd1);
    store(8'h44);
    chk("inrdy_full", {31'd0, mmio_data_in_ready}, 32'd0);
    chk("ovf_pre", {31'd0, tx_overflow}, 32'd0);
    store(8'h45);
    chk("ovf_set", {31'd0, tx_overflow}, 32'd1);
    tx_ready = 1'b1;
    exp_seq[0] = 8'h41; exp_seq[1] = 8'h42; exp_seq[2] = 8'h43; exp_seq[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_v%0d", i), {31'd0, tx_valid}, 32'd1);
      chk($sformatf("drain_d%0d", i), {24'd0, tx_data}, {24'd0, exp_seq[i]});
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("drain_empty", {31'd0, tx_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, tx_overflow}, 32'd1);
    mmio_reset_cnt = 1'b1;
    @(negedge clk);
    mmio_reset_cnt = 1'b0;
    chk("ovf_clr", {31'd0, tx_overflow}, 32'd0);

    // 2 entries, simultaneous push and pop
    store(8'h51);
    store(8'h52);
    tx_ready = 1'b1;
    chk("pp_head", {24'd0, tx_data}, 32'h51);
    store(8'h55);
    tx_ready = 1'b0;
    chk("pp_head2", {24'd0, tx_data}, 32'h52);
    store(8'h56);
    chk("pp_occ3", {31'd0, mmio_data_in_ready}, 32'd1);
    store(8'h57);
    chk("pp_occ4", {31'd0, mmio_data_in_ready}, 32'd0);
    tx_ready = 1'b1;
    exp_seq[0] = 8'h52; exp_seq[1] = 8'h55; exp_seq[2] = 8'h56; exp_seq[3] = 8'h57;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pp_d%0d", i), {24'd0, tx_data}, {24'd0, exp_seq[i]});
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("pp_empty", {31'd0, tx_valid}, 32'd0);

    // RX holding register
    rx_valid = 1'b1; rx_data = 8'h7A;
    chk("rx_rdy0", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    chk("rx_v1", {31'd0, mmio_data_out_valid}, 32'd1);
    chk("rx_d1", {24'd0, mmio_uart_data_out}, 32'h7A);
    chk("rx_rdy1", {31'd0, rx_ready}, 32'd0);
    rx_data = 8'h7B;
    @(negedge clk);
    chk("rx_hold", {24'd0, mmio_uart_data_out}, 32'h7A);
    load_from_uart = 1'b1;
    @(negedge clk);
    load_from_uart = 1'b0;
    chk("rx_clr_v", {31'd0, mmio_data_out_valid}, 32'd0);
    chk("rx_clr_rdy", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("rx_v2", {31'd0, mmio_data_out_valid}, 32'd1);
    chk("rx_d2", {24'd0, mmio_uart_data_out}, 32'h7B);

    // async reset with 3 TX bytes and RX full
    store(8'h61);
    store(8'h62);
    store(8'h63);
    chk("pre_rst_v", {31'd0, tx_valid}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("arst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cyc", mmio_cycle_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
